clk_lock_detector: RTL and testbench
====================================

CLK_LOCK_DETECTOR -- requirements
Module: clk_lock_detector

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 1024: clk_ref cycles per measurement window (>=16).
REQ-002 SHALL have parameter CNT_W, default 24: width of monitored-clock counter and measurement.
REQ-003 SHALL have parameter LOCK_COUNT, default 4: consecutive good windows required to declare lock.
REQ-004 SHALL have parameter UNLOCK_COUNT, default 2: consecutive bad windows required to drop lock.
REQ-005 SHALL have port clk_ref  input  1  reference clock; all outputs and control in this domain.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-low, clk_ref domain.
REQ-007 SHALL have port clk_mon  input  1  monitored clock, asynchronous to clk_ref, may stop.
REQ-008 SHALL have port enable  input  1  measurement enable.
REQ-009 SHALL have port expected_min  input  CNT_W  lowest in-tolerance clk_mon count per window.
REQ-010 SHALL have port expected_max  input  CNT_W  highest in-tolerance clk_mon count per window.
REQ-011 SHALL have port locked  output  1  frequency-lock status; feeds downstream unlock counters.
REQ-012 SHALL have port meas_count  output  CNT_W  clk_mon edges counted in last completed window.
REQ-013 SHALL have port meas_valid  output  1  one-cycle pulse when meas_count updates.
REQ-014 SHALL have port state  output  2  FSM state: 0 IDLE, 1 PRIME, 2 ACQUIRE, 3 LOCKED.

Function
REQ-015 SHALL run a free-running CNT_W-bit binary counter on clk_mon with no reset, registered as Gray code.
REQ-016 SHALL cross the Gray count into clk_ref via a 2-flop synchronizer, then convert to binary.
REQ-017 SHALL run a window counter 0..WINDOW_CYCLES-1 in clk_ref while enable=1; terminal count = window end.
REQ-018 SHALL, at each window end, compute delta = (sync_count - prev_count) mod 2^CNT_W and store sync_count as prev_count.
REQ-019 SHALL, at window end in ACQUIRE or LOCKED, register meas_count<=delta and pulse meas_valid for exactly one cycle.
REQ-020 SHALL classify a window good iff expected_min <= delta <= expected_max (unsigned, sampled at window end); min>max never good.
REQ-021 SHALL treat a stopped clk_mon (delta=0) as bad unless expected_min=0.
REQ-022 IDLE: enable=1 -> PRIME, window counter cleared.
REQ-023 PRIME: first window end only loads prev_count, no meas_valid, -> ACQUIRE.
REQ-024 ACQUIRE: good increments good_cnt; good_cnt reaching LOCK_COUNT -> LOCKED, good_cnt cleared; bad clears good_cnt.
REQ-025 LOCKED: bad increments bad_cnt; bad_cnt reaching UNLOCK_COUNT -> ACQUIRE, bad_cnt cleared; good clears bad_cnt.
REQ-026 SHALL assert locked iff state=LOCKED; locked changes on the same edge as the meas_valid pulse causing the transition.
REQ-027 SHALL, when enable=0 in any state, enter IDLE next cycle, clear locked, good_cnt, bad_cnt, window counter; meas_count holds.
REQ-028 SHALL handle clk_mon counter wrap via modular subtraction; no special case.
REQ-029 good_cnt/bad_cnt SHALL be wide enough for their parameter and never exceed it.

Reset
REQ-030 SHALL, with reset=0 on a clk_ref edge, set state=IDLE, locked=0, meas_valid=0, meas_count=0, counters 0, prev_count=0.
REQ-031 SHALL abandon any window in progress on reset; first window after release is PRIME (discarded).
REQ-032 clk_mon-domain counter and synchronizer SHALL NOT be reset.

Verification
REQ-033 clk_ref 100 MHz, clk_mon 125 MHz, min=1275, max=1285, enable=1 -> meas_count 1279..1281, locked=1 at 5th window end (1 prime + 4 good).
REQ-034 Locked, then clk_mon stopped -> two meas_valid with meas_count=0, locked=0 on second, state=2.
REQ-035 Locked, one window at 150 MHz (delta~1536) then back to 125 MHz -> locked stays 1, bad_cnt clears.
REQ-036 clk_mon counter preloaded near 2^24-1 across window end -> meas_count still ~1280, no glitch in locked.
REQ-037 enable deasserted mid-window while locked -> locked=0 and state=0 next cycle; re-enable -> PRIME, relock after 5 windows.
REQ-038 reset=0 for one cycle mid-window while locked -> all outputs to reset values; min=1290,max=1270 afterwards -> never locks.

Source files
------------

// File: rtl/clk_lock_detector.sv
// Frequency lock detector: counts clk_mon edges over fixed clk_ref windows and
// declares lock after enough consecutive in-tolerance windows.
`timescale 1ns/1ps

module clk_lock_detector #(
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned UNLOCK_COUNT  = 2
) (
    input  logic             clk_ref,
    input  logic             reset,
    input  logic             clk_mon,
    input  logic             enable,
    input  logic [CNT_W-1:0] expected_min,
    input  logic [CNT_W-1:0] expected_max,
    output logic             locked,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic [1:0]       state
);

    localparam int unsigned WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRIME   = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    // ---------------- clk_mon domain: free-running count, Gray encoded
    logic [CNT_W-1:0] mon_bin_q;
    logic [CNT_W-1:0] mon_bin_d;
    logic [CNT_W-1:0] mon_gray_q;

    always_comb begin
        mon_bin_d = mon_bin_q + CNT_W'(1);
    end

    always_ff @(posedge clk_mon) begin
        mon_bin_q  <= mon_bin_d;
        mon_gray_q <= mon_bin_d ^ (mon_bin_d >> 1);
    end

    // ---------------- clk_ref domain: 2-flop Gray synchronizer
    logic [CNT_W-1:0] sync1_q;
    logic [CNT_W-1:0] sync2_q;
    logic [CNT_W-1:0] sync_bin_c;

    always_ff @(posedge clk_ref) begin
        sync1_q <= mon_gray_q;
        sync2_q <= sync1_q;
    end

    always_comb begin
        sync_bin_c = '0;
        for (int i = 0; i < int'(CNT_W); i++) begin
            sync_bin_c[i] = ^(sync2_q >> i);
        end
    end

    // ---------------- measurement and lock FSM
    state_e            state_q, state_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  prev_q, prev_d;
    logic [CNT_W-1:0]  meas_count_q, meas_count_d;
    logic              meas_valid_q, meas_valid_d;
    logic              locked_q, locked_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
    logic              win_end_c;
    logic [CNT_W-1:0]  delta_c;
    logic              good_c;

    assign win_end_c = (win_q == WIN_W'(WINDOW_CYCLES - 1));
    // Modular subtraction absorbs counter wrap; min > max can never classify good.
    assign delta_c   = sync_bin_c - prev_q;
    assign good_c    = (delta_c >= expected_min) && (delta_c <= expected_max);

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        prev_d       = prev_q;
        meas_count_d = meas_count_q;
        meas_valid_d = 1'b0;
        good_cnt_d   = good_cnt_q;
        bad_cnt_d    = bad_cnt_q;

        if (!enable) begin
            state_d    = ST_IDLE;
            win_d      = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_PRIME;
            win_d   = '0;
        end else begin
            win_d = win_end_c ? '0 : win_q + WIN_W'(1);
            if (win_end_c) begin
                prev_d = sync_bin_c;
                case (state_q)
                    ST_PRIME: begin
                        state_d = ST_ACQUIRE;
                    end
                    ST_ACQUIRE: begin
                        meas_valid_d = 1'b1;
                        meas_count_d = delta_c;
                        if (!good_c) begin
                            good_cnt_d = '0;
                        end else if (good_cnt_q == GOOD_W'(LOCK_COUNT - 1)) begin
                            state_d    = ST_LOCKED;
                            good_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + GOOD_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        meas_valid_d = 1'b1;
                        meas_count_d = delta_c;
                        if (good_c) begin
                            bad_cnt_d = '0;
                        end else if (bad_cnt_q == BAD_W'(UNLOCK_COUNT - 1)) begin
                            state_d   = ST_ACQUIRE;
                            bad_cnt_d = '0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + BAD_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end

        // Lock status follows the next state so it moves with the meas_valid pulse.
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_ref) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            win_q        <= '0;
            prev_q       <= '0;
            meas_count_q <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            good_cnt_q   <= '0;
            bad_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            prev_q       <= prev_d;
            meas_count_q <= meas_count_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
        end
    end

    assign locked     = locked_q;
    assign meas_count = meas_count_q;
    assign meas_valid = meas_valid_q;
    assign state      = state_q;

endmodule

// File: tb/tb_clk_lock_detector.sv
// Directed bench for clk_lock_detector: 100 MHz reference, 125/150 MHz or stopped monitor.
`timescale 1ns/1ps

module tb_clk_lock_detector;

    localparam int unsigned CW  = 24;
    localparam int unsigned CWW = 12;

    logic          clk_ref = 1'b0;
    logic          clk_mon = 1'b0;
    logic          reset   = 1'b0;
    logic          enable  = 1'b0;
    logic [CW-1:0] exp_min = '0;
    logic [CW-1:0] exp_max = '0;

    logic          locked, meas_valid;
    logic [CW-1:0] meas_count;
    logic [1:0]    state;
    logic           locked_w, meas_valid_w;
    logic [CWW-1:0] meas_count_w;
    logic [1:0]     state_w;

    bit      mon_run  = 1'b1;
    realtime mon_half = 4.0;

    int n_checks = 0;
    int n_fail   = 0;

    clk_lock_detector dut (
        .clk_ref(clk_ref), .reset(reset), .clk_mon(clk_mon), .enable(enable),
        .expected_min(exp_min), .expected_max(exp_max),
        .locked(locked), .meas_count(meas_count), .meas_valid(meas_valid), .state(state)
    );

    // Narrow counter wraps every few windows, exercising modular subtraction.
    clk_lock_detector #(.CNT_W(CWW)) dut_w (
        .clk_ref(clk_ref), .reset(reset), .clk_mon(clk_mon), .enable(enable),
        .expected_min(exp_min[CWW-1:0]), .expected_max(exp_max[CWW-1:0]),
        .locked(locked_w), .meas_count(meas_count_w), .meas_valid(meas_valid_w), .state(state_w)
    );

    always #5 clk_ref = ~clk_ref;

    initial begin
        forever begin
            if (mon_run) begin
                #(mon_half);
                clk_mon = ~clk_mon;
            end else begin
                #1;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, required completion before 1 ms");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input int budget, output int cycles, output bit got);
        got    = 1'b0;
        cycles = 0;
        while (cycles < budget && !got) begin
            @(posedge clk_ref);
            #1;
            cycles++;
            if (meas_valid) got = 1'b1;
        end
    endtask

    task automatic wait_lock(input int max_pulses, output bit ok);
        int c;
        bit got;
        ok = 1'b0;
        for (int p = 0; p < max_pulses; p++) begin
            wait_valid(2200, c, got);
            if (!got) break;
            if (locked) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        enable  = 1'b0;
        exp_min = CW'(1275);
        exp_max = CW'(1285);
        repeat (3) @(posedge clk_ref);
        #1;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%0b exp=0", locked); end
        n_checks++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", meas_valid); end
        n_checks++; if (meas_count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", meas_count); end
        n_checks++; if (state_w !== 2'd0) begin n_fail++; $display("FAIL reset_state_w got=%0d exp=0", state_w); end
        reset = 1'b1;
    endtask

    task automatic test_lock();
        int c;
        bit got;
        enable = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            wait_valid(2200, c, got);
            n_checks++;
            if (!got) begin
                n_fail++; $display("FAIL lock_pulse%0d no meas_valid within 2200 cycles", p);
            end else begin
                if (p == 1) begin
                    n_checks++;
                    if (c < 1500) begin n_fail++; $display("FAIL prime_discard first pulse after %0d cycles, exp >1500", c); end
                end
                n_checks++;
                if (meas_count < 1279 || meas_count > 1281) begin
                    n_fail++; $display("FAIL lock_count%0d got=%0d exp=1279..1281", p, meas_count);
                end
                n_checks++;
                if (locked !== (p == 4)) begin
                    n_fail++; $display("FAIL lock_status%0d got=%0b exp=%0b", p, locked, (p == 4));
                end
            end
        end
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL lock_state got=%0d exp=3", state); end
        @(posedge clk_ref); #1;
        n_checks++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL valid_one_cycle got=%0b exp=0", meas_valid); end
    endtask

    task automatic test_stop();
        int c;
        bit got, ok;
        mon_run = 1'b0;
        wait_valid(2200, c, got);
        n_checks++;
        if (!got || locked !== 1'b1 || meas_count >= 1275) begin
            n_fail++; $display("FAIL stop_first got_valid=%0b locked=%0b count=%0d exp valid=1 locked=1 count<1275", got, locked, meas_count);
        end
        wait_valid(2200, c, got);
        n_checks++;
        if (!got || meas_count !== '0 || locked !== 1'b0 || state !== 2'd2) begin
            n_fail++; $display("FAIL stop_second got_valid=%0b count=%0d locked=%0b state=%0d exp 1/0/0/2", got, meas_count, locked, state);
        end
        mon_run = 1'b1;
        wait_lock(8, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stop_relock got=0 exp=1"); end
    endtask

    task automatic test_fast();
        int c;
        bit got;
        for (int p = 0; p < 4; p++) begin
            mon_half = (p % 2 == 0) ? 3.333 : 4.0;
            wait_valid(2200, c, got);
            n_checks++;
            if (!got || locked !== 1'b1) begin
                n_fail++; $display("FAIL fast_locked%0d got_valid=%0b locked=%0b exp 1/1", p, got, locked);
            end
            n_checks++;
            if (p % 2 == 0 && meas_count <= 1500) begin
                n_fail++; $display("FAIL fast_count%0d got=%0d exp>1500", p, meas_count);
            end else if (p % 2 == 1 && (meas_count < 1275 || meas_count > 1285)) begin
                n_fail++; $display("FAIL slow_count%0d got=%0d exp=1275..1285", p, meas_count);
            end
        end
        mon_half = 4.0;
    endtask

    task automatic test_wrap();
        int pulses = 0;
        int glitches = 0;
        int cycles = 0;
        n_checks++; if (locked_w !== 1'b1) begin n_fail++; $display("FAIL wrap_start locked_w got=%0b exp=1", locked_w); end
        while (pulses < 6 && cycles < 7000) begin
            @(posedge clk_ref); #1;
            cycles++;
            if (locked_w !== 1'b1 || locked !== 1'b1) glitches++;
            if (meas_valid_w) begin
                pulses++;
                n_checks++;
                if (meas_count_w < 1279 || meas_count_w > 1281) begin
                    n_fail++; $display("FAIL wrap_count%0d got=%0d exp=1279..1281", pulses, meas_count_w);
                end
            end
        end
        n_checks++; if (pulses != 6) begin n_fail++; $display("FAIL wrap_pulses got=%0d exp=6", pulses); end
        n_checks++; if (glitches != 0) begin n_fail++; $display("FAIL wrap_glitch cycles_unlocked=%0d exp=0", glitches); end
    endtask

    task automatic test_disable();
        int c;
        bit got;
        repeat (500) @(posedge clk_ref);
        #1;
        enable = 1'b0;
        @(posedge clk_ref); #1;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL dis_state got=%0d exp=0", state); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL dis_locked got=%0b exp=0", locked); end
        n_checks++;
        if (meas_count < 1275 || meas_count > 1285) begin
            n_fail++; $display("FAIL dis_hold got=%0d exp=1275..1285", meas_count);
        end
        repeat (5) @(posedge clk_ref);
        #1;
        enable = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            wait_valid(2200, c, got);
            n_checks++;
            if (!got) begin
                n_fail++; $display("FAIL reen_pulse%0d no meas_valid within 2200 cycles", p);
            end else begin
                if (p == 1) begin
                    n_checks++;
                    if (c < 1500) begin n_fail++; $display("FAIL reen_prime first pulse after %0d cycles, exp >1500", c); end
                end
                n_checks++;
                if (locked !== (p == 4)) begin
                    n_fail++; $display("FAIL reen_status%0d got=%0b exp=%0b", p, locked, (p == 4));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int glitches = 0;
        int bad_state = 0;
        repeat (300) @(posedge clk_ref);
        #1;
        reset = 1'b0;
        @(posedge clk_ref); #1;
        reset = 1'b1;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rmid_state got=%0d exp=0", state); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rmid_locked got=%0b exp=0", locked); end
        n_checks++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%0b exp=0", meas_valid); end
        n_checks++; if (meas_count !== '0) begin n_fail++; $display("FAIL rmid_count got=%0d exp=0", meas_count); end
        exp_min = CW'(1290);
        exp_max = CW'(1270);
        @(posedge clk_ref); #1;
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL rmid_prime got=%0d exp=1", state); end
        for (int i = 0; i < 7 * 1024 + 512; i++) begin
            @(posedge clk_ref); #1;
            if (locked !== 1'b0) glitches++;
            if (meas_valid) begin
                pulses++;
                if (state !== 2'd2) bad_state++;
            end
        end
        n_checks++; if (pulses != 6) begin n_fail++; $display("FAIL rmid_pulses got=%0d exp=6", pulses); end
        n_checks++; if (glitches != 0) begin n_fail++; $display("FAIL rmid_never_lock locked_cycles=%0d exp=0", glitches); end
        n_checks++; if (bad_state != 0) begin n_fail++; $display("FAIL rmid_acquire non_acquire_pulses=%0d exp=0", bad_state); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_stop();
        test_fast();
        test_wrap();
        test_disable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
